mips_mc_ctrl: RTL
=================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The module SHALL have these ports, clock and reset first, one per line:
  clk  input  1  single system clock; all state changes on rising edge
  rst_n  input  1  reset, asynchronous, active-low
  opcode  input  6  instruction bits [31:26], stable from DECODE until return to FETCH
  funct  input  6  instruction bits [5:0], stable from DECODE until return to FETCH
  zero  input  1  ALU Zero flag (Result == 0)
  mem_ready  input  1  memory access completes this cycle
  pc_en  output  1  PC register load enable
  ir_write  output  1  instruction register load enable
  mem_write  output  1  data memory write strobe
  reg_write  output  1  register file write enable
  iord  output  1  memory address select: 0 = PC, 1 = ALUOut
  mem_to_reg  output  1  write-back data select: 0 = ALUOut, 1 = memory data
  reg_dst  output  1  destination register select: 0 = rt, 1 = rd
  alu_src_a  output  1  ALU A select: 0 = PC, 1 = reg A
  alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
  pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
  alu_ctrl  output  4  4-bit ALU opcode driven to the 32-bit ALU
  illegal  output  1  one-cycle pulse on an unsupported opcode or funct
  state  output  4  current FSM state, debug
REQ-002 Reset SHALL be asynchronous and active-low on rst_n; clk SHALL be the only clock.

Function
REQ-003 ALU opcodes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-004 The FSM state encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-005 Outputs SHALL be decoded combinationally from state, plus the listed inputs; every output not listed for a state SHALL be 0, except alu_ctrl, which defaults to ADD.
REQ-006 FETCH outputs SHALL be alu_src_b=01 and alu_ctrl=ADD, with ir_write=pc_en=mem_ready; the FSM SHALL hold in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-007 DECODE outputs SHALL be alu_src_b=11 and alu_ctrl=ADD, with next state by opcode:
  100011 (lw) or 101011 (sw) -> MEMADR
  000000 (R-type) -> EXEC
  000100 (beq) -> BRANCH
  001000 (addi) -> ADDIEX
  000010 (j) -> JUMP
  any other opcode -> FETCH, with illegal=1 for that cycle
REQ-008 MEMADR outputs SHALL be alu_src_a=1, alu_src_b=10, alu_ctrl=ADD; next state SHALL be MEMRD for lw and MEMWR for sw.
REQ-009 MEMRD SHALL drive iord=1 and hold until mem_ready=1, then go to MEMWB.
REQ-010 MEMWB SHALL drive mem_to_reg=1, reg_write=1, reg_dst=0; next state FETCH.
REQ-011 MEMWR SHALL drive iord=1 and mem_write=mem_ready, and hold until mem_ready=1; next state FETCH.
REQ-012 EXEC SHALL drive alu_src_a=1 and alu_src_b=00, with alu_ctrl from funct; next state ALUWB. funct mapping:
  100000 -> ADD
  100010 -> SUB
  100100 -> AND
  100101 -> OR
  100111 -> NOR
  101010 -> SLT
  any other funct -> ADD, with illegal=1 during EXEC
REQ-013 ALUWB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-014 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01 and pc_en=zero; next state FETCH.
REQ-015 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=ADD; next state ADDIWB.
REQ-016 ADDIWB SHALL drive reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-017 JUMP SHALL drive pc_src=10 and pc_en=1; next state FETCH.
REQ-018 Unused encodings 12-15 SHALL return to FETCH on the next edge with all write enables 0.
REQ-019 Cycle counts with mem_ready held at 1 SHALL be:
  lw 5
  sw 4
  R-type 4
  addi 4
  beq 3
  j 3
REQ-020 illegal SHALL be asserted for at most one cycle per instruction.

Reset
REQ-021 While rst_n=0, state SHALL be FETCH, and pc_en, ir_write, mem_write, reg_write and illegal SHALL be forced to 0.
REQ-022 Asserting rst_n mid-instruction SHALL abort that instruction immediately with no further write enables; after release, execution SHALL begin in FETCH on the first clock edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  lw, mem_ready=1 throughout -> states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 only in state 4.
  R-type with funct 101010 -> alu_ctrl=0111 in EXEC; reg_write=1 and reg_dst=1 in ALUWB; 4 cycles total.
  beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first, pc_en=0 for the second.
  sw with mem_ready=0 for 3 cycles in MEMWR -> FSM holds; mem_write=0 until the mem_ready=1 cycle, then exactly one mem_write pulse.
  opcode 111111 -> illegal=1 for one cycle in DECODE, return to FETCH, no write enables asserted.
  rst_n driven low in ALUWB -> reg_write=0 immediately; state=0 while rst_n is low; FETCH resumes after release.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: a 12-state FSM that sequences fetch, decode and
// execution of lw/sw/R-type/beq/addi/j, with outputs decoded from the current state.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_reg;
    logic       op_known;
    logic       fn_known;
    logic [3:0] fn_alu;

    assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

    // Unknown funct still executes as ADD so the datapath sees a defined opcode.
    always_comb begin
        fn_known = 1'b1;
        fn_alu   = ALU_ADD;
        case (funct)
            6'b100000: fn_alu = ALU_ADD;
            6'b100010: fn_alu = ALU_SUB;
            6'b100100: fn_alu = ALU_AND;
            6'b100101: fn_alu = ALU_OR;
            6'b100111: fn_alu = ALU_NOR;
            6'b101010: fn_alu = ALU_SLT;
            default: begin
                fn_alu   = ALU_ADD;
                fn_known = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= S_EXEC;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_ADDI:      state_reg <= S_ADDIEX;
                        OP_J:         state_reg <= S_JUMP;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_reg <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_reg <= S_MEMWB;
                S_MEMWB:  state_reg <= S_FETCH;
                S_MEMWR:  if (mem_ready) state_reg <= S_FETCH;
                S_EXEC:   state_reg <= S_ALUWB;
                S_ALUWB:  state_reg <= S_FETCH;
                S_BRANCH: state_reg <= S_FETCH;
                S_ADDIEX: state_reg <= S_ADDIWB;
                S_ADDIWB: state_reg <= S_FETCH;
                S_JUMP:   state_reg <= S_FETCH;
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_b = 2'b01;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = ~op_known;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = fn_alu;
                illegal   = ~fn_known;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence every write strobe at once, not just after the state clears.
        if (!rst_n) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state = state_reg;

endmodule
